instr_fetch: RTL and testbench

- Instruction fetch stage. Produces the instruction word and the `opcode` field that feed the main control decoder and the register file.
- Owns the PC and talks to instruction memory over a req/ack handshake.
- Holds the instruction in an output register with a one-entry skid buffer, so decode stalls never drop a fetched word.
- Accepts branch/jump redirects from the execute stage.

---
 rtl/instr_fetch_if.sv | 15 +
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : byte address of the request, word aligned (fetch -> memory)
//   imem_ack   : memory returns imem_rdata this cycle (memory -> fetch)
//   imem_rdata : instruction word, valid only with imem_ack (memory -> fetch)
// master = fetch stage side, slave = memory side.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// presents the instruction in an output register backed by a one-entry skid
// buffer, and accepts redirects from execute.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   imem (master)     : instruction memory req/addr/ack/rdata
//   i_stall           : decode cannot accept a new instruction this cycle
//   i_redirect        : taken branch/jump, flush in-flight work
//   i_redirect_pc     : new PC (bits[1:0] ignored)
//   o_instr_valid     : output register holds a real instruction
//   o_instr, o_opcode : instruction word and its [31:26] field
//   o_pc_out          : fetch address of o_instr
//   o_pc_plus4        : o_pc_out + 4
module instr_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [31:0]          i_redirect_pc,
  output logic                 o_instr_valid,
  output logic [31:0]          o_instr,
  output logic [5:0]           o_opcode,
  output logic [31:0]          o_pc_out,
  output logic [31:0]          o_pc_plus4
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;  // address of the request abandoned by a redirect
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_skid_instr;  // skid contents are meaningful only in S_HOLD
  logic [31:0] r_skid_pc;

  logic        w_can_accept;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  assign w_can_accept  = !r_valid || !i_stall;
  assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4    = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= PC_RESET;
      r_drain_addr <= 32'd0;
      r_valid      <= 1'b0;
      r_instr      <= 32'd0;
      r_pc_out     <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
    end else if (i_redirect) begin
      // Redirect beats everything else; any coincident response is dropped.
      r_pc         <= w_redirect_pc;
      r_valid      <= 1'b0;
      r_instr      <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      if (r_state != S_HOLD && !imem.imem_ack) begin
        // A request is still outstanding: keep it alive until it acks.
        r_state <= S_DRAIN;
        if (r_state == S_FETCH) begin
          r_drain_addr <= r_pc;
        end
      end else begin
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem.imem_ack) begin
            r_pc <= w_pc_plus4;
            if (w_can_accept) begin
              r_instr  <= imem.imem_rdata;
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
            end else begin
              r_skid_instr <= imem.imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= S_HOLD;
            end
          end else if (r_valid && !i_stall) begin
            // Consumed with nothing to replace it: present a NOP.
            r_valid <= 1'b0;
            r_instr <= 32'd0;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            r_instr  <= r_skid_instr;
            r_pc_out <= r_skid_pc;
            r_valid  <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Stale response is discarded; r_pc already holds the new target.
          if (imem.imem_ack) begin
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem.imem_req  = !rst && (r_state == S_FETCH || r_state == S_DRAIN);
  assign imem.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  assign o_instr_valid = r_valid;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[31:26];
  assign o_pc_out      = r_pc_out;
  assign o_pc_plus4    = r_pc_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vector table, hand-written multi-cycle
// sequences, a PC-wrap instance, and a randomized run checked against a
// program-order model of the instruction stream.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: PC_RESET = 0
  instr_fetch_if ifa ();
  logic        rst_a, stall_a, redir_a;
  logic [31:0] rpc_a;
  logic        valid_a;
  logic [31:0] instr_a, pc_out_a, pc_p4_a;
  logic [5:0]  opc_a;

  instr_fetch #(.PC_RESET(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst_a), .imem(ifa.master),
    .i_stall(stall_a), .i_redirect(redir_a), .i_redirect_pc(rpc_a),
    .o_instr_valid(valid_a), .o_instr(instr_a), .o_opcode(opc_a),
    .o_pc_out(pc_out_a), .o_pc_plus4(pc_p4_a)
  );

  // DUT B: PC_RESET near the top of the address space, zero-wait memory
  instr_fetch_if ifb ();
  logic        rst_b, stall_b, redir_b;
  logic [31:0] rpc_b;
  logic        valid_b;
  logic [31:0] instr_b, pc_out_b, pc_p4_b;
  logic [5:0]  opc_b;

  instr_fetch #(.PC_RESET(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .imem(ifb.master),
    .i_stall(stall_b), .i_redirect(redir_b), .i_redirect_pc(rpc_b),
    .o_instr_valid(valid_b), .o_instr(instr_b), .o_opcode(opc_b),
    .o_pc_out(pc_out_b), .o_pc_plus4(pc_p4_b)
  );

  assign ifb.imem_ack   = 1'b1;
  assign ifb.imem_rdata = ifb.imem_addr ^ KEY;

  int checks = 0;
  int errors = 0;
  logic        s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of DUT A inputs (called at a negedge), capture the
  // request seen by memory during this cycle, then return at the next negedge.
  task automatic run_cycle(input logic r, input logic a, input logic s, input logic rd,
                           input logic [31:0] rpc, input logic [31:0] rdata);
    rst_a = r; ifa.imem_ack = a; ifa.imem_rdata = rdata;
    stall_a = s; redir_a = rd; rpc_a = rpc;
    #1;
    s_req  = ifa.imem_req;
    s_addr = ifa.imem_addr;
    @(negedge clk);
  endtask

  // Checks of registered outputs after an edge; pc fields only when valid.
  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] einstr);
    logic [31:0] ei;
    ei = ev ? einstr : 32'd0;
    chk({tag, "_valid"}, {31'd0, valid_a}, {31'd0, ev});
    chk({tag, "_instr"}, instr_a, ei);
    chk({tag, "_opcode"}, {26'd0, opc_a}, {26'd0, ei[31:26]});
    if (ev) begin
      chk({tag, "_pc_out"}, pc_out_a, epc);
      chk({tag, "_pc_plus4"}, pc_p4_a, epc + 32'd4);
    end
  endtask

  typedef struct {
    logic        rst, ack, stall, redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic a, input logic s, input logic rd,
                              input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.ack = a; v.stall = s; v.redir = rd; v.rpc = rpc;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_pc = epc;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    int          outstanding;
    int          lat;
    int          idle;
    int          consumed;
    logic [31:0] maddr;
    logic [31:0] exp_pc;
    logic        s, rd, a;
    logic [31:0] rpc, rdata;

    rst_a = 1'b1; stall_a = 1'b0; redir_a = 1'b0; rpc_a = 32'd0;
    ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'd0;
    rst_b = 1'b1; stall_b = 1'b0; redir_b = 1'b0; rpc_b = 32'd0;

    //           rst ack stl rd  rpc            req addr          v  pc
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h0,         1, 32'h0);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h4);
    tbl[4]  = mk(0, 1, 0, 0, 32'h0,         1, 32'h8,         1, 32'h8);
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,         1, 32'hC,         0, 32'h0);
    tbl[6]  = mk(0, 1, 0, 0, 32'h0,         1, 32'hC,         1, 32'hC);
    tbl[7]  = mk(0, 1, 1, 0, 32'h0,         1, 32'h10,        1, 32'hC);
    tbl[8]  = mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC);
    tbl[9]  = mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC);
    tbl[10] = mk(0, 0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC);
    tbl[11] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h10);
    tbl[12] = mk(0, 1, 0, 0, 32'h0,         1, 32'h14,        1, 32'h14);
    tbl[13] = mk(0, 1, 1, 1, 32'h203,       1, 32'h18,        0, 32'h0);
    tbl[14] = mk(0, 1, 0, 0, 32'h0,         1, 32'h200,       1, 32'h200);
    tbl[15] = mk(0, 0, 0, 0, 32'h0,         1, 32'h204,       0, 32'h0);

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      run_cycle(tbl[i].rst, tbl[i].ack, tbl[i].stall, tbl[i].redir, tbl[i].rpc,
                tbl[i].ack ? wd(tbl[i].exp_addr) : 32'hDEAD_BEEF);
      chk($sformatf("vec%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk_out($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_pc, wd(tbl[i].exp_pc));
      $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc_out=%h",
               i, s_req, s_addr, valid_a, instr_a, pc_out_a);
    end

    // 3-cycle ack latency: address held, exactly one instruction delivered.
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, (i == 2), 0, 0, 32'h0, (i == 2) ? wd(32'h204) : 32'h1234_5678);
      chk($sformatf("lat%0d_req", i), {31'd0, s_req}, 32'd1);
      chk($sformatf("lat%0d_addr", i), s_addr, 32'h204);
      chk_out($sformatf("lat%0d", i), (i == 2), 32'h204, wd(32'h204));
      $display("lat %0d: addr=%h valid=%0b instr=%h", i, s_addr, valid_a, instr_a);
    end
    run_cycle(0, 0, 0, 0, 32'h0, 32'h0);
    chk("lat3_addr", s_addr, 32'h208);
    chk_out("lat3", 1'b0, 32'h0, 32'h0);
    $display("lat 3: addr=%h valid=%0b", s_addr, valid_a);

    // Redirect with a request outstanding, then a second redirect in DRAIN.
    run_cycle(0, 0, 0, 1, 32'h100, 32'h0);
    chk("drain0_addr", s_addr, 32'h208);
    chk_out("drain0", 1'b0, 32'h0, 32'h0);
    run_cycle(0, 0, 0, 1, 32'h302, 32'h0);
    chk("drain1_req", {31'd0, s_req}, 32'd1);
    chk("drain1_addr", s_addr, 32'h208);
    chk_out("drain1", 1'b0, 32'h0, 32'h0);
    run_cycle(0, 1, 0, 0, 32'h0, wd(32'h208));
    chk("drain2_addr", s_addr, 32'h208);
    chk_out("drain2", 1'b0, 32'h0, 32'h0);
    run_cycle(0, 1, 0, 0, 32'h0, wd(32'h300));
    chk("drain3_addr", s_addr, 32'h300);
    chk_out("drain3", 1'b1, 32'h300, wd(32'h300));
    $display("drain: resumed addr=%h valid=%0b instr=%h", s_addr, valid_a, instr_a);

    // Reset in the middle of a DRAIN.
    run_cycle(0, 0, 0, 1, 32'h40, 32'h0);
    chk("rstd0_addr", s_addr, 32'h304);
    run_cycle(0, 0, 0, 0, 32'h0, 32'h0);
    chk("rstd1_addr", s_addr, 32'h304);
    run_cycle(1, 0, 0, 0, 32'h0, 32'h0);
    chk("rstd2_req", {31'd0, s_req}, 32'd0);
    chk_out("rstd2", 1'b0, 32'h0, 32'h0);
    run_cycle(0, 1, 0, 0, 32'h0, wd(32'h0));
    chk("rstd3_req", {31'd0, s_req}, 32'd1);
    chk("rstd3_addr", s_addr, 32'h0);
    chk_out("rstd3", 1'b1, 32'h0, wd(32'h0));
    $display("rst-in-drain: restart addr=%h valid=%0b", s_addr, valid_a);

    // PC wrap on DUT B.
    rst_b = 1'b0;
    #1;
    chk("wrap0_req", {31'd0, ifb.imem_req}, 32'd1);
    chk("wrap0_addr", ifb.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap1_addr", ifb.imem_addr, 32'hFFFF_FFFC);
    chk("wrap1_pc_out", pc_out_b, 32'hFFFF_FFF8);
    chk("wrap1_instr", instr_b, wd(32'hFFFF_FFF8));
    @(negedge clk);
    chk("wrap2_addr", ifb.imem_addr, 32'h0000_0000);
    chk("wrap2_pc_out", pc_out_b, 32'hFFFF_FFFC);
    chk("wrap2_pc_plus4", pc_p4_b, 32'h0000_0000);
    @(negedge clk);
    chk("wrap3_pc_out", pc_out_b, 32'h0000_0000);
    chk("wrap3_valid", {31'd0, valid_b}, 32'd1);
    $display("wrap: pc_out=%h instr=%h", pc_out_b, instr_b);

    // Randomized run: the consumed stream must follow program order,
    // restarting at each redirect target.
    run_cycle(1, 0, 0, 0, 32'h0, 32'h0);
    run_cycle(1, 0, 0, 0, 32'h0, 32'h0);
    rst_a = 1'b0;
    outstanding = 0; lat = 0; maddr = 32'h0;
    exp_pc = 32'h0; idle = 0; consumed = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (valid_a) begin
        chk("rnd_pc_out", pc_out_a, exp_pc);
        chk("rnd_instr", instr_a, wd(exp_pc));
        chk("rnd_pc_plus4", pc_p4_a, exp_pc + 32'd4);
      end else begin
        chk("rnd_nop", instr_a, 32'h0);
      end
      s   = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 31) == 0);
      rpc = $urandom & 32'h0000_0FFF;
      a   = 1'b0;
      if (ifa.imem_req) begin
        if (outstanding == 0) begin
          outstanding = 1;
          lat = $urandom_range(0, 3);
          maddr = ifa.imem_addr;
        end else begin
          chk("rnd_addr_stable", ifa.imem_addr, maddr);
        end
        a = (lat == 0);
      end else if (outstanding != 0) begin
        chk("rnd_req_dropped", {31'd0, ifa.imem_req}, 32'd1);
      end
      rdata = a ? wd(ifa.imem_addr) : $urandom;
      ifa.imem_ack = a; ifa.imem_rdata = rdata;
      stall_a = s; redir_a = rd; rpc_a = rpc;
      idle++;
      if (rd) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        idle = 0;
      end else if (valid_a && !s) begin
        $display("rnd %0d: consumed pc=%h instr=%h", cyc, pc_out_a, instr_a);
        exp_pc = exp_pc + 32'd4;
        consumed++;
        idle = 0;
      end
      if (idle > 60) begin
        chk("rnd_progress_timeout", idle, 32'd0);
        break;
      end
      @(posedge clk);
      if (a) outstanding = 0;
      else if (outstanding != 0) lat--;
      @(negedge clk);
    end
    chk("rnd_consumed_enough", {31'd0, consumed > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
